cond_ctrl_pipe: RTL

- Parametrised control-path pipeline for the pipelined core. It carries decoded control bits from Decode through Execute and NSTAGES later stages (default M, W).
- It evaluates the full 16-code condition field against a registered NZCV flags register, gates the side-effecting controls, and updates the flags.
- It generalises the fixed E/M/W control chain: configurable stage depth and payload width, a stall input, a valid bit, full condition decoding, and an optional performance counter set.

---
 rtl/cond_ctrl_pkg.sv | 41 ++++
 rtl/cond_eval.sv | 39 +++
 rtl/cond_ctrl_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cond_ctrl_pkg.sv
// Shared constants for the conditional control pipeline: ARM condition codes,
// NZCV bit positions and the decoded control bundle.
package cond_ctrl_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic branch;
        logic regwrite;
        logic memwrite;
        logic pcsrc;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: 4-bit condition against NZCV.
module cond_eval
    import cond_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = ~(n ^ v);
            COND_LT: pass = n ^ v;
            COND_GT: pass = ~z & ~(n ^ v);
            COND_LE: pass = z | (n ^ v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_ctrl_pipe.sv
// Control-path pipeline D -> E -> stages 1..NSTAGES with condition gating and NZCV flags.
// Optional performance counters are enabled with COND_CTRL_PERF_EN.
module cond_ctrl_pipe
    import cond_ctrl_pkg::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter int NSTAGES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_d,
    input  logic [3:0]           cond_d,
    input  logic [1:0]           flagwrite_d,
    input  logic                 branch_d,
    input  logic                 regwrite_d,
    input  logic                 memwrite_d,
    input  logic                 pcsrc_d,
    input  logic [PAYLOAD_W-1:0] payload_d,
    input  logic                 stall_e,
    input  logic                 flush_e,
    input  logic [3:0]           alu_flags_e,
    output logic                 cond_ex_e,
    output logic                 branch_taken_e,
    output logic [PAYLOAD_W-1:0] payload_e,
    output logic [3:0]           flags_q,
    output logic                 regwrite_m,
    output logic                 memwrite_m,
    output logic                 pcsrc_m,
    output logic [PAYLOAD_W-1:0] payload_m,
    output logic                 regwrite_w,
    output logic                 pcsrc_w,
    output logic [PAYLOAD_W-1:0] payload_w,
    output logic                 pc_wr_pending
`ifdef COND_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_retired_o,
    output logic [31:0]          perf_squashed_o,
    output logic [31:0]          perf_br_taken_o
`endif
);

    logic                 valid_e_q, valid_e_d;
    logic [3:0]           cond_e_q, cond_e_d;
    logic [1:0]           flagwrite_e_q, flagwrite_e_d;
    ctrl_t                ctrl_e_q, ctrl_e_d;
    logic [PAYLOAD_W-1:0] payload_e_q, payload_e_d;
    logic [3:0]           flags_d;
    logic [NSTAGES-1:0]   regwrite_s_q, regwrite_s_d;
    logic [NSTAGES-1:0]   pcsrc_s_q, pcsrc_s_d;
    logic                 memwrite_m_q, memwrite_m_d;
    logic [PAYLOAD_W-1:0] payload_s_q [NSTAGES];
    logic [PAYLOAD_W-1:0] payload_s_d [NSTAGES];
    logic                 run_q, run_d;
    logic                 cond_pass;

    cond_eval u_cond_eval (
        .cond  (cond_e_q),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    assign cond_ex_e      = cond_pass & valid_e_q;
    assign branch_taken_e = ctrl_e_q.branch & cond_ex_e;
    assign payload_e      = payload_e_q;
    assign regwrite_m     = regwrite_s_q[0];
    assign memwrite_m     = memwrite_m_q;
    assign pcsrc_m        = pcsrc_s_q[0];
    assign payload_m      = payload_s_q[0];
    assign regwrite_w     = regwrite_s_q[NSTAGES-1];
    assign pcsrc_w        = pcsrc_s_q[NSTAGES-1];
    assign payload_w      = payload_s_q[NSTAGES-1];

    // run_q keeps the combinational D term quiet until the first edge after reset.
    assign run_d         = 1'b1;
    assign pc_wr_pending = run_q & (pcsrc_d | ctrl_e_q.pcsrc | (|pcsrc_s_q[NSTAGES-2:0]));

    always_comb begin
        valid_e_d     = valid_e_q;
        cond_e_d      = cond_e_q;
        flagwrite_e_d = flagwrite_e_q;
        ctrl_e_d      = ctrl_e_q;
        payload_e_d   = payload_e_q;
        if (flush_e) begin
            valid_e_d     = 1'b0;
            cond_e_d      = '0;
            flagwrite_e_d = '0;
            ctrl_e_d      = '0;
            payload_e_d   = '0;
        end else if (!stall_e) begin
            valid_e_d     = valid_d;
            cond_e_d      = cond_d;
            flagwrite_e_d = flagwrite_d;
            ctrl_e_d      = '{branch: branch_d, regwrite: regwrite_d,
                              memwrite: memwrite_d, pcsrc: pcsrc_d};
            payload_e_d   = payload_d;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (cond_ex_e && !stall_e) begin
            if (flagwrite_e_q[1]) begin
                flags_d[FLAG_N] = alu_flags_e[FLAG_N];
                flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
            end
            if (flagwrite_e_q[0]) begin
                flags_d[FLAG_C] = alu_flags_e[FLAG_C];
                flags_d[FLAG_V] = alu_flags_e[FLAG_V];
            end
        end
    end

    // A stalled E instruction stays put, so stage 1 takes a bubble behind it.
    always_comb begin
        regwrite_s_d   = {regwrite_s_q[NSTAGES-2:0], 1'b0};
        pcsrc_s_d      = {pcsrc_s_q[NSTAGES-2:0], 1'b0};
        memwrite_m_d   = 1'b0;
        payload_s_d[0] = '0;
        for (int i = 1; i < NSTAGES; i++) begin
            payload_s_d[i] = payload_s_q[i-1];
        end
        if (!stall_e) begin
            regwrite_s_d[0] = ctrl_e_q.regwrite & cond_ex_e;
            pcsrc_s_d[0]    = ctrl_e_q.pcsrc & cond_ex_e;
            memwrite_m_d    = ctrl_e_q.memwrite & cond_ex_e;
            payload_s_d[0]  = payload_e_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_e_q     <= 1'b0;
            cond_e_q      <= '0;
            flagwrite_e_q <= '0;
            ctrl_e_q      <= '0;
            payload_e_q   <= '0;
            flags_q       <= '0;
            regwrite_s_q  <= '0;
            pcsrc_s_q     <= '0;
            memwrite_m_q  <= 1'b0;
            run_q         <= 1'b0;
            for (int i = 0; i < NSTAGES; i++) begin
                payload_s_q[i] <= '0;
            end
        end else begin
            valid_e_q     <= valid_e_d;
            cond_e_q      <= cond_e_d;
            flagwrite_e_q <= flagwrite_e_d;
            ctrl_e_q      <= ctrl_e_d;
            payload_e_q   <= payload_e_d;
            flags_q       <= flags_d;
            regwrite_s_q  <= regwrite_s_d;
            pcsrc_s_q     <= pcsrc_s_d;
            memwrite_m_q  <= memwrite_m_d;
            run_q         <= run_d;
            for (int i = 0; i < NSTAGES; i++) begin
                payload_s_q[i] <= payload_s_d[i];
            end
        end
    end

`ifdef COND_CTRL_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] squashed_q, squashed_d;
    logic [31:0] br_taken_q, br_taken_d;

    always_comb begin
        retired_d  = sat_inc(retired_q,  ~stall_e & valid_e_q & cond_ex_e);
        squashed_d = sat_inc(squashed_q, ~stall_e & valid_e_q & ~cond_ex_e);
        br_taken_d = sat_inc(br_taken_q, ~stall_e & branch_taken_e);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q  <= '0;
            squashed_q <= '0;
            br_taken_q <= '0;
        end else begin
            retired_q  <= retired_d;
            squashed_q <= squashed_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign perf_retired_o  = retired_q;
    assign perf_squashed_o = squashed_q;
    assign perf_br_taken_o = br_taken_q;
`endif

endmodule
